// File: rtl/maf_mc_sched.sv
// maf_mc_sched: multi-channel moving-average scheduler.
// Up to NCH sample sources share one TAPS-tap moving-sum datapath through a
// round-robin arbiter. Each channel keeps a private history and running sum;
// the granted channel's updated sum is emitted one cycle after acceptance.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   req         per-channel sample request
//   din         packed 5-bit samples, channel i at [5i+4:5i]
//   clear       per-channel clear of history and sum
//   gnt         one-hot grant, combinational from req, clear and rr_ptr
//   dout_valid  one-cycle pulse per accepted sample (registered)
//   dout_ch     channel index of dout (registered)
//   dout        moving sum of that channel's last TAPS samples (registered)
module maf_mc_sched #(
  parameter int NCH  = 4,
  parameter int TAPS = 6,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req,
  input  logic [5*NCH-1:0] din,
  input  logic [NCH-1:0]   clear,
  output logic [NCH-1:0]   gnt,
  output logic             dout_valid,
  output logic [CW-1:0]    dout_ch,
  output logic [7:0]       dout
);

  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [4:0]    h_q [NCH][TAPS];
  logic [4:0]    h_d [NCH][TAPS];
  logic [7:0]    s_q [NCH];
  logic [7:0]    s_d [NCH];
  logic          dout_valid_q, dout_valid_d;
  logic [CW-1:0] dout_ch_q, dout_ch_d;
  logic [7:0]    dout_q, dout_d;

  logic [NCH-1:0] elig;
  logic [CW-1:0]  cand;
  logic [CW-1:0]  gnt_idx;
  logic           acc;
  logic [4:0]     x;
  logic [7:0]     new_sum;

  // Round-robin search starting just after the last granted channel.
  // A channel being cleared is not eligible, so its request stays pending.
  always_comb begin
    elig    = req & ~clear;
    gnt     = '0;
    gnt_idx = '0;
    acc     = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CW'((int'(rr_ptr_q) + k) % NCH);
      if (!acc && elig[cand]) begin
        acc          = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    h_d          = h_q;
    s_d          = s_q;
    dout_valid_d = 1'b0;
    dout_ch_d    = dout_ch_q;
    dout_d       = dout_q;
    x            = din[5*gnt_idx +: 5];
    // Modulo-256 arithmetic is safe: the true sum never exceeds 31*TAPS.
    new_sum      = s_q[gnt_idx] + {3'b000, x} - {3'b000, h_q[gnt_idx][TAPS-1]};

    for (int i = 0; i < NCH; i++) begin
      if (clear[i]) begin
        s_d[i] = '0;
        for (int k = 0; k < TAPS; k++) h_d[i][k] = '0;
      end
    end

    // The granted channel is never one being cleared, so no conflict here.
    if (acc) begin
      for (int k = TAPS-1; k > 0; k--) h_d[gnt_idx][k] = h_q[gnt_idx][k-1];
      h_d[gnt_idx][0] = x;
      s_d[gnt_idx]    = new_sum;
      rr_ptr_d        = gnt_idx;
      dout_valid_d    = 1'b1;
      dout_ch_d       = gnt_idx;
      dout_d          = new_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= CW'(NCH-1);
      dout_valid_q <= 1'b0;
      dout_ch_q    <= '0;
      dout_q       <= '0;
      for (int i = 0; i < NCH; i++) begin
        s_q[i] <= '0;
        for (int k = 0; k < TAPS; k++) h_q[i][k] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      dout_valid_q <= dout_valid_d;
      dout_ch_q    <= dout_ch_d;
      dout_q       <= dout_d;
      s_q          <= s_d;
      h_q          <= h_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_ch    = dout_ch_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_maf_mc_sched.sv
// Directed bench for maf_mc_sched (NCH=4, TAPS=6). Expected grants are given
// per step; expected outputs come from a reference model that keeps the raw
// sample window per channel and sums it, pushed to a scoreboard queue when a
// step is driven and popped when the DUT output is sampled.
module tb_maf_mc_sched;
  localparam int NCH  = 4;
  localparam int TAPS = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] din;
  logic [3:0]  clear;
  logic [3:0]  gnt;
  logic        dout_valid;
  logic [1:0]  dout_ch;
  logic [7:0]  dout;

  maf_mc_sched #(.NCH(NCH), .TAPS(TAPS)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .clear(clear),
    .gnt(gnt), .dout_valid(dout_valid), .dout_ch(dout_ch), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] ch;
    logic [7:0] sum;
  } exp_t;

  exp_t sb[$];
  int   hist[NCH][$];
  int   hold_ch;
  int   hold_sum;
  int   compared;
  int   mismatched;

  function automatic logic [19:0] pk(input int s0, input int s1, input int s2, input int s3);
    return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic [3:0] r, input logic [19:0] d,
                     input logic [3:0] c, input logic [3:0] eg, input string tag);
    exp_t e;
    int   ch;
    int   s;
    @(negedge clk);
    reset = rst; req = r; din = d; clear = c;
    #1;
    if (!rst) chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    if (rst) begin
      for (int i = 0; i < NCH; i++) hist[i].delete();
      hold_ch  = 0;
      hold_sum = 0;
      e.v      = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) if (c[i]) hist[i].delete();
      if (eg != 4'b0000) begin
        ch = 0;
        for (int i = 0; i < NCH; i++) if (eg[i]) ch = i;
        hist[ch].push_front(int'(d[5*ch +: 5]));
        if (hist[ch].size() > TAPS) void'(hist[ch].pop_back());
        s = 0;
        for (int k = 0; k < hist[ch].size(); k++) s += hist[ch][k];
        hold_ch  = ch;
        hold_sum = s;
        e.v      = 1'b1;
      end else begin
        e.v = 1'b0;
      end
    end
    e.ch  = 2'(hold_ch);
    e.sum = 8'(hold_sum);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_valid"}, 32'(dout_valid), 32'(e.v));
    chk({tag, "_ch"},    32'(dout_ch),    32'(e.ch));
    chk({tag, "_dout"},  32'(dout),       32'(e.sum));
  endtask

  initial begin
    compared = 0; mismatched = 0; hold_ch = 0; hold_sum = 0;
    reset = 1'b1; req = '0; din = '0; clear = '0;

    cyc(1, 4'b0000, '0, 4'b0000, 4'b0000, "rst0");
    cyc(1, 4'b0000, '0, 4'b0000, 4'b0000, "rst1");
    cyc(0, 4'b0000, '0, 4'b0000, 4'b0000, "idle0");

    // ch0 alone: 1..7 -> 1,3,6,10,15,21,27
    for (int n = 1; n <= 7; n++) cyc(0, 4'b0001, pk(n, 0, 0, 0), 4'b0000, 4'b0001, "ch0_ramp");

    // ch1 alone streaming 31: saturates at 186
    for (int n = 0; n < 8; n++) cyc(0, 4'b0010, pk(0, 31, 0, 0), 4'b0000, 4'b0010, "ch1_max");
    cyc(0, 4'b0000, pk(0, 31, 0, 0), 4'b0000, 4'b0000, "hold");

    // all channels after reset: 0001,0010,0100,1000 repeating
    cyc(1, 4'b1111, pk(1, 2, 3, 4), 4'b0000, 4'b0000, "rst2");
    for (int n = 0; n < 3; n++) begin
      cyc(0, 4'b1111, pk(1, 2, 3, 4), 4'b0000, 4'b0001, "rr0");
      cyc(0, 4'b1111, pk(1, 2, 3, 4), 4'b0000, 4'b0010, "rr1");
      cyc(0, 4'b1111, pk(1, 2, 3, 4), 4'b0000, 4'b0100, "rr2");
      cyc(0, 4'b1111, pk(1, 2, 3, 4), 4'b0000, 4'b1000, "rr3");
    end

    // ch0 history 5,5,5 then clear with pending request
    cyc(0, 4'b0000, '0, 4'b0001, 4'b0000, "clr_pre");
    for (int n = 0; n < 3; n++) cyc(0, 4'b0001, pk(5, 0, 0, 0), 4'b0000, 4'b0001, "ch0_five");
    cyc(0, 4'b0011, pk(2, 9, 0, 0), 4'b0101, 4'b0010, "clr_ch1_acc");
    cyc(0, 4'b0001, pk(2, 0, 0, 0), 4'b0000, 4'b0001, "after_clr");

    // build ch3 sum 40 (4,4,4 + 10,10,8), then reset mid-stream
    cyc(0, 4'b1000, pk(0, 0, 0, 10), 4'b0000, 4'b1000, "ch3_a");
    cyc(0, 4'b1000, pk(0, 0, 0, 10), 4'b0000, 4'b1000, "ch3_b");
    cyc(0, 4'b1000, pk(0, 0, 0, 8),  4'b0000, 4'b1000, "ch3_40");
    cyc(1, 4'b1000, pk(0, 0, 0, 7),  4'b0000, 4'b0000, "rst_mid");
    cyc(0, 4'b1000, pk(0, 0, 0, 7),  4'b0000, 4'b1000, "ch3_after");

    cyc(1, 4'b1111, pk(1, 2, 3, 4), 4'b0000, 4'b0000, "rst3");
    cyc(0, 4'b1111, pk(1, 2, 3, 4), 4'b0000, 4'b0001, "first_ch0");
    cyc(0, 4'b1111, pk(1, 2, 3, 4), 4'b0000, 4'b0010, "then_ch1");
    cyc(0, 4'b0000, '0, 4'b0000, 4'b0000, "idle_end");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
